// File: rtl/nv_ram_rwsthp_20x32_fifo_ctl.sv
// FIFO controller for the 20x32 rwsthp RAM: drives the RAM port side and
// exposes valid/ready push and pop interfaces, with a bypass fast path when empty.
module nv_ram_rwsthp_20x32_fifo_ctl (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_pvld,
    output logic        wr_prdy,
    input  logic [31:0] wr_pd,
    output logic        rd_pvld,
    input  logic        rd_prdy,
    output logic [31:0] rd_pd,
    output logic [4:0]  fifo_cnt,
    output logic [4:0]  ram_wa,
    output logic        ram_we,
    output logic [31:0] ram_di,
    output logic [4:0]  ram_ra,
    output logic        ram_re,
    output logic        ram_ore,
    output logic        ram_byp_sel,
    output logic [31:0] ram_dbyp,
    input  logic [31:0] ram_dout,
    input  logic [31:0] pwrbus_ram_pd,
    output logic [31:0] ram_pwrbus_ram_pd
);

    localparam int DEPTH = 20;
    localparam int WIDTH = 32;
    localparam int AW    = 5;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] FULL_CNT = AW'(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    unread_cnt;
    logic             s1_vld;
    logic             s2_vld;

    logic [AW-1:0]    ram_cnt;
    logic             wr_acc;
    logic             rd_acc;
    logic             out_free;
    logic             bypass;
    logic             ore_normal;
    logic             issue;
    logic             write_ram;

    // Occupancy of the RAM side: words waiting to be issued plus the one in ra_d.
    always_comb begin
        ram_cnt    = unread_cnt + {{(AW-1){1'b0}}, s1_vld};
        wr_prdy    = (ram_cnt != FULL_CNT);
        wr_acc     = wr_pvld & wr_prdy;
        rd_acc     = s2_vld & rd_prdy;
        out_free   = ~s2_vld | rd_prdy;
        bypass     = wr_acc & (ram_cnt == '0) & out_free;
        ore_normal = s1_vld & out_free;
        issue      = (unread_cnt != '0) & (~s1_vld | ore_normal);
        write_ram  = wr_acc & ~bypass;
    end

    always_comb begin
        ram_we            = ~rst & write_ram;
        ram_wa            = wr_ptr;
        ram_di            = wr_pd;
        ram_re            = ~rst & issue;
        ram_ra            = rd_ptr;
        ram_ore           = ~rst & (bypass | ore_normal);
        ram_byp_sel       = ~rst & bypass;
        ram_dbyp          = wr_pd;
        rd_pvld           = s2_vld;
        rd_pd             = ram_dout;
        fifo_cnt          = ram_cnt + {{(AW-1){1'b0}}, s2_vld};
        ram_pwrbus_ram_pd = pwrbus_ram_pd;
    end

    // A reissue in the same cycle as an output load keeps s1 occupied.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            unread_cnt <= '0;
            s1_vld     <= 1'b0;
            s2_vld     <= 1'b0;
        end else begin
            if (write_ram) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + AW'(1);
            end
            if (issue) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + AW'(1);
            end
            unread_cnt <= unread_cnt + {{(AW-1){1'b0}}, write_ram}
                                     - {{(AW-1){1'b0}}, issue};
            if (issue) begin
                s1_vld <= 1'b1;
            end else if (ore_normal) begin
                s1_vld <= 1'b0;
            end
            if (bypass | ore_normal) begin
                s2_vld <= 1'b1;
            end else if (rd_acc) begin
                s2_vld <= 1'b0;
            end
        end
    end

    logic unused_width;
    assign unused_width = (WIDTH == 32);

endmodule

// File: doc/nv_ram_rwsthp_20x32_fifo_ctl.md
Name: nv_ram_rwsthp_20x32_fifo_ctl

Overview:
- FIFO controller that drives the port side of the 20x32 rwsthp RAM model: write address/enable/data, read address/enable, output-register enable, and the bypass mux.
- Presents a valid/ready write interface and a valid/ready read interface to NVDLA pipeline logic.
- Manages the RAM's 2-stage read (address latch, then output register) without bubbles.
- Uses the RAM bypass path as an empty-FIFO fast path, giving 1-cycle latency.

Parameters:
- DEPTH, 20, RAM entries. Fixed to the RAM instance; not overridable.
- WIDTH, 32, data width. Fixed.
- AW, 5, address width. Fixed.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- wr_pvld  in  1  write valid
- wr_prdy  out  1  write ready
- wr_pd  in  32  write data
- rd_pvld  out  1  read valid
- rd_prdy  in  1  read ready
- rd_pd  out  32  read data; equals ram_dout
- fifo_cnt  out  5  total occupancy, 0..21 (RAM entries plus output register)
- ram_wa  out  5  RAM write address
- ram_we  out  1  RAM write enable
- ram_di  out  32  RAM write data
- ram_ra  out  5  RAM read address
- ram_re  out  1  RAM read-address latch enable
- ram_ore  out  1  RAM output-register enable
- ram_byp_sel  out  1  RAM bypass select
- ram_dbyp  out  32  RAM bypass data
- ram_dout  in  32  RAM registered output
- pwrbus_ram_pd  in  32  power bus
- ram_pwrbus_ram_pd  out  32  combinational pass-through of pwrbus_ram_pd

Behaviour:
- Reset values (rst high at a clk edge):
  - wr_ptr=0, rd_ptr=0, ram_cnt=0, unread_cnt=0, s1_vld=0, s2_vld=0.
  - Outputs: rd_pvld=0, fifo_cnt=0, wr_prdy=1.
  - All RAM enables are 0 while rst is high.
  - rd_pd is X until the first ore; the bench checks it only when rd_pvld=1.
  - Reset mid-operation discards all contents; no RAM clear is required.
- State:
  - s1_vld: RAM ra_d holds an issued entry.
  - s2_vld: RAM dout_r holds data. rd_pvld=s2_vld.
  - unread_cnt: entries written but not yet issued.
  - ram_cnt = unread_cnt + s1_vld, range 0..20.
- Flow control:
  - wr_prdy = (ram_cnt != 20).
  - wr_acc = wr_pvld & wr_prdy.
  - rd_acc = rd_pvld & rd_prdy.
  - out_free = !s2_vld | rd_prdy.
- Bypass path, taken when wr_acc & ram_cnt==0 & out_free:
  - ram_byp_sel=1, ram_dbyp=wr_pd, ram_ore=1, ram_we=0.
  - Next cycle: s2_vld=1, rd_pd=wr_pd. Latency 1.
- Normal write, taken on wr_acc with no bypass:
  - ram_we=1, ram_wa=wr_ptr, ram_di=wr_pd.
  - wr_ptr increments, wrapping 19->0.
  - unread_cnt increments.
- Read issue:
  - ram_re = (unread_cnt != 0) & (!s1_vld | ram_ore_normal).
  - ram_ra = rd_ptr. On issue, rd_ptr wraps 19->0, unread_cnt decrements, s1_vld is set.
  - unread_cnt counts only entries written in earlier cycles; no same-cycle write-to-read.
- Output load:
  - ram_ore_normal = s1_vld & out_free, with byp_sel=0.
  - Clears s1_vld unless a new re is issued in the same cycle.
  - Sets s2_vld.
  - ram_cnt decrements.
- Mutual exclusion: bypass and ore_normal never coincide, because bypass requires ram_cnt==0, which implies s1_vld=0.
- s2_vld is cleared on rd_acc without a simultaneous ore.
- Latencies:
  - Bypass: 1 cycle.
  - Non-bypass, pipeline unstalled: write at t, re at t+1, ore at t+2, rd_pvld at t+3.
  - Sustained throughput is 1/cycle once primed.
- Stall: with rd_prdy=0, dout_r and ra_d hold; re/ore are 0 for the held stages. The entry under ra_d is not freed until ore, so it is never overwritten.
- Simultaneous wr_acc and rd_acc at ram_cnt==20: the write is refused (wr_prdy=0) even though a pop occurs; wr_prdy depends on registered state only.
- fifo_cnt = ram_cnt + s2_vld.

Test Plan:
- Reset, then one write 0xA5A5_0001 with rd_prdy=1 -> ram_byp_sel=1, ram_we=0; rd_pvld=1 and rd_pd=0xA5A5_0001 next cycle; fifo_cnt 1 then 0.
- rd_prdy=0; write 0x0..0x14 back-to-back -> first word bypassed; 20 RAM writes at wa 0..19; wr_prdy=0 after the 21st accept; fifo_cnt=21.
- From full, hold rd_prdy=1 -> 21 words pop in order 0x0..0x14 on consecutive cycles with no bubbles; wr_prdy returns 1 the cycle after the first RAM-side ore.
- Continuous push/pop for 100 words with random rd_prdy (50%) -> in-order data; ram_wa/ram_ra wrap 19->0; no overwrite of an entry held in ra_d.
- Write while s2_vld=1 and rd_prdy=0 (FIFO otherwise empty) -> no bypass; RAM write at wa=wr_ptr; word appears 2 cycles after rd_prdy rises.
- Assert rst with 10 entries queued -> next cycle rd_pvld=0, fifo_cnt=0, wr_prdy=1; a subsequent write takes the bypass path.
